// File: rtl/ob_cntrl_match_seq_if.sv
// Order-book shared types and the bundle that joins the match sequencer to the
// order-entry controller, match engine, bid/ask tables and trade output FIFO.
package ob_pkg;
  typedef logic [15:0] quantity_t;
  typedef logic [31:0] price_t;

  // One match engine result: traded quantity plus which head(s) it used up.
  typedef struct packed {
    price_t    bid_price;
    price_t    ask_price;
    quantity_t qty;
    quantity_t remainder;
    logic      bid_consumed;
    logic      ask_consumed;
  } search_result_t;
endpackage

interface ob_cntrl_match_seq_if #(
  parameter int CNT_W = 4
);
  import ob_pkg::*;

  logic             match_req;
  logic             match_busy;
  logic             match_done_r;
  logic             match_capped_r;
  logic [CNT_W-1:0] match_cnt_r;

  logic             trade_qry;
  logic             trade_vld_r;
  search_result_t   trade_r;

  logic             bid_pop_r;
  logic             ask_pop_r;
  logic             bid_upd_r;
  logic             ask_upd_r;
  quantity_t        upd_qty_r;
  logic             tbl_ack;

  logic             trd_out_vld_r;
  search_result_t   trd_out_r;
  logic             trd_out_rdy;

  modport master (
    input  match_req, trade_vld_r, trade_r, tbl_ack, trd_out_rdy,
    output match_busy, match_done_r, match_capped_r, match_cnt_r, trade_qry,
           bid_pop_r, ask_pop_r, bid_upd_r, ask_upd_r, upd_qty_r,
           trd_out_vld_r, trd_out_r
  );

  modport slave (
    output match_req, trade_vld_r, trade_r, tbl_ack, trd_out_rdy,
    input  match_busy, match_done_r, match_capped_r, match_cnt_r, trade_qry,
           bid_pop_r, ask_pop_r, bid_upd_r, ask_upd_r, upd_qty_r,
           trd_out_vld_r, trd_out_r
  );
endinterface

// File: rtl/ob_cntrl_match_seq.sv
// Match episode sequencer: query engine, commit pop/update to the tables, forward
// each trade downstream, let the tables settle and re-query until empty or capped.
module ob_cntrl_match_seq
  import ob_pkg::*;
#(
  parameter int MAX_TRADES    = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = $clog2(MAX_TRADES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  ob_cntrl_match_seq_if.master bus
);

  localparam int               SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SET_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_TRADES);

  typedef enum logic [2:0] {
    IDLE,
    QRY,
    RESP,
    COMMIT,
    SETTLE
  } state_e;

  state_e           state_q;
  logic             pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic             capped_q;
  logic             done_q;
  logic [SET_W-1:0] settle_q;
  logic             bid_pop_q;
  logic             ask_pop_q;
  logic             bid_upd_q;
  logic             ask_upd_q;
  quantity_t        upd_qty_q;
  logic             trd_vld_q;
  search_result_t   trd_q;
  logic             tbl_done_q;
  logic             out_done_q;

  logic             cmd_any_d;
  logic             tbl_fin_d;
  logic             out_fin_d;
  logic             trade_ok_d;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cmd_any_d  = bid_pop_q | ask_pop_q | bid_upd_q | ask_upd_q;
    // A handshake counts as finished from the cycle its ack/ready is seen.
    tbl_fin_d  = tbl_done_q | (cmd_any_d & bus.tbl_ack);
    out_fin_d  = out_done_q | (trd_vld_q & bus.trd_out_rdy);
    trade_ok_d = bus.trade_vld_r & (bus.trade_r.bid_consumed | bus.trade_r.ask_consumed);
    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  // NOTE: every register here uses <= so all branches see pre-edge values; the
  // trade hold register is reset with everything else so a reset mid-episode
  // never leaves a stale payload on trd_out_r.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      capped_q   <= 1'b0;
      done_q     <= 1'b0;
      settle_q   <= '0;
      bid_pop_q  <= 1'b0;
      ask_pop_q  <= 1'b0;
      bid_upd_q  <= 1'b0;
      ask_upd_q  <= 1'b0;
      upd_qty_q  <= '0;
      trd_vld_q  <= 1'b0;
      trd_q      <= '0;
      tbl_done_q <= 1'b0;
      out_done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.match_req && (state_q != IDLE)) begin
        pend_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (bus.match_req || pend_q) begin
            state_q  <= QRY;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            capped_q <= 1'b0;
          end
        end

        QRY: state_q <= RESP;

        RESP: begin
          if (trade_ok_d) begin
            trd_q      <= bus.trade_r;
            trd_vld_q  <= 1'b1;
            cnt_q      <= cnt_d;
            bid_pop_q  <= bus.trade_r.bid_consumed;
            ask_pop_q  <= bus.trade_r.ask_consumed;
            // The side that survives gets its head quantity rewritten.
            bid_upd_q  <= ~bus.trade_r.bid_consumed;
            ask_upd_q  <= ~bus.trade_r.ask_consumed;
            upd_qty_q  <= (bus.trade_r.bid_consumed && bus.trade_r.ask_consumed)
                          ? '0 : bus.trade_r.remainder;
            tbl_done_q <= 1'b0;
            out_done_q <= 1'b0;
            state_q    <= COMMIT;
          end else begin
            state_q  <= IDLE;
            done_q   <= 1'b1;
            capped_q <= 1'b0;
          end
        end

        COMMIT: begin
          if (cmd_any_d && bus.tbl_ack) begin
            bid_pop_q <= 1'b0;
            ask_pop_q <= 1'b0;
            bid_upd_q <= 1'b0;
            ask_upd_q <= 1'b0;
            upd_qty_q <= '0;
          end
          if (trd_vld_q && bus.trd_out_rdy) begin
            trd_vld_q <= 1'b0;
          end

          if (tbl_fin_d && out_fin_d) begin
            tbl_done_q <= 1'b0;
            out_done_q <= 1'b0;
            if (cnt_q == CNT_MAX) begin
              state_q  <= IDLE;
              done_q   <= 1'b1;
              capped_q <= 1'b1;
            end else if (SETTLE_CYCLES == 0) begin
              state_q <= QRY;
            end else begin
              state_q  <= SETTLE;
              settle_q <= SETTLE_LOAD;
            end
          end else begin
            tbl_done_q <= tbl_fin_d;
            out_done_q <= out_fin_d;
          end
        end

        SETTLE: begin
          if (settle_q == '0) begin
            state_q <= QRY;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.match_busy     = (state_q != IDLE);
  assign bus.match_done_r   = done_q;
  assign bus.match_capped_r = capped_q;
  assign bus.match_cnt_r    = cnt_q;
  assign bus.trade_qry      = (state_q == QRY);
  assign bus.bid_pop_r      = bid_pop_q;
  assign bus.ask_pop_r      = ask_pop_q;
  assign bus.bid_upd_r      = bid_upd_q;
  assign bus.ask_upd_r      = ask_upd_q;
  assign bus.upd_qty_r      = upd_qty_q;
  assign bus.trd_out_vld_r  = trd_vld_q;
  assign bus.trd_out_r      = trd_q;

  // A valid engine result must consume at least one head.
  a_trade_consumes: assert property (@(posedge clk) disable iff (!rst)
    (state_q == RESP && bus.trade_vld_r) |-> (bus.trade_r.bid_consumed || bus.trade_r.ask_consumed));

  a_side_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(bid_pop_q && bid_upd_q) && !(ask_pop_q && ask_upd_q));

endmodule

// File: tb/tb_ob_cntrl_match_seq.sv
// Randomised self-checking bench for ob_cntrl_match_seq with scripted engine,
// table and downstream responders and a quantity-level expectation model.
module tb_ob_cntrl_match_seq;
  import ob_pkg::*;

  localparam int MAX_TRADES    = 8;
  localparam int SETTLE_CYCLES = 1;
  localparam int CNT_W         = $clog2(MAX_TRADES + 1);

  typedef struct packed {
    logic      bid_pop;
    logic      ask_pop;
    logic      bid_upd;
    logic      ask_upd;
    quantity_t qty;
  } cmd_t;

  localparam int OUT_W = 4 + CNT_W + $bits(cmd_t) + 1 + $bits(search_result_t);

  logic clk = 1'b0;
  logic rst = 1'b0;

  ob_cntrl_match_seq_if #(.CNT_W(CNT_W)) bus ();

  ob_cntrl_match_seq #(
    .MAX_TRADES   (MAX_TRADES),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc = 0, qry_seen = 0, done_count = 0, done_cyc = 0;
  int tbl_dly = 0, rdy_dly = 0, tbl_k = 0, rdy_k = 0, n_loaded = 0;
  logic             done_capped;
  logic [CNT_W-1:0] done_cnt;
  search_result_t   resp_q[$], got_trd[$], exp_trd[$];
  cmd_t             got_cmd[$], exp_cmd[$];
  int               qry_cycs[$];

  function automatic cmd_t cur_cmd();
    cmd_t c;
    c.bid_pop = bus.bid_pop_r;
    c.ask_pop = bus.ask_pop_r;
    c.bid_upd = bus.bid_upd_r;
    c.ask_upd = bus.ask_upd_r;
    c.qty     = bus.upd_qty_r;
    return c;
  endfunction

  function automatic logic [OUT_W-1:0] outs();
    return {bus.match_busy, bus.match_done_r, bus.match_capped_r, bus.match_cnt_r,
            bus.trade_qry, cur_cmd(), bus.trd_out_vld_r, bus.trd_out_r};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Match engine: registered response one cycle after each query strobe.
  initial begin
    bus.trade_vld_r = 1'b0;
    bus.trade_r     = '0;
    forever begin
      @(negedge clk);
      if (bus.trade_qry === 1'b1) begin
        qry_seen++;
        qry_cycs.push_back(cyc);
        @(posedge clk);
        #1;
        if (resp_q.size() > 0) begin
          bus.trade_r     = resp_q.pop_front();
          bus.trade_vld_r = 1'b1;
        end else begin
          bus.trade_r     = '0;
          bus.trade_vld_r = 1'b0;
        end
        @(posedge clk);
        #1 bus.trade_vld_r = 1'b0;
      end
    end
  end

  // Table responder: ack tbl_dly cycles after a command first appears.
  initial begin
    bus.tbl_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (cur_cmd() != '0) begin
        bus.tbl_ack = (tbl_k == tbl_dly);
        tbl_k++;
      end else begin
        bus.tbl_ack = 1'b0;
        tbl_k       = 0;
      end
    end
  end

  // Downstream responder: ready rdy_dly cycles after valid first appears.
  initial begin
    bus.trd_out_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.trd_out_vld_r === 1'b1) begin
        bus.trd_out_rdy = (rdy_k == rdy_dly);
        rdy_k++;
      end else begin
        bus.trd_out_rdy = 1'b0;
        rdy_k           = 0;
      end
    end
  end

  // Monitor: collects completed beats/commands and checks hold-until-ack stability.
  initial begin
    logic           trd_pend, cmd_pend;
    search_result_t prev_trd;
    cmd_t           prev_cmd;
    trd_pend = 1'b0;
    cmd_pend = 1'b0;
    prev_trd = '0;
    prev_cmd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        trd_pend = 1'b0;
        cmd_pend = 1'b0;
      end else begin
        if (bus.trd_out_vld_r === 1'b1) begin
          if (trd_pend) begin
            checks++;
            if (bus.trd_out_r !== prev_trd) begin
              fails++;
              $display("FAIL trd_out_stable: got %h expected %h", bus.trd_out_r, prev_trd);
            end
          end
          if (bus.trd_out_rdy) begin
            got_trd.push_back(bus.trd_out_r);
            trd_pend = 1'b0;
          end else begin
            trd_pend = 1'b1;
            prev_trd = bus.trd_out_r;
          end
        end else if (trd_pend) begin
          checks++;
          fails++;
          $display("FAIL trd_out_dropped: got vld 0 expected vld 1");
          trd_pend = 1'b0;
        end

        if (cur_cmd() != '0) begin
          if (cmd_pend) begin
            checks++;
            if (cur_cmd() !== prev_cmd) begin
              fails++;
              $display("FAIL cmd_stable: got %h expected %h", cur_cmd(), prev_cmd);
            end
          end
          if (bus.tbl_ack) begin
            got_cmd.push_back(cur_cmd());
            cmd_pend = 1'b0;
          end else begin
            cmd_pend = 1'b1;
            prev_cmd = cur_cmd();
          end
        end else if (cmd_pend) begin
          checks++;
          fails++;
          $display("FAIL cmd_dropped: got none expected %h", prev_cmd);
          cmd_pend = 1'b0;
        end

        if (bus.match_done_r === 1'b1) begin
          done_count++;
          done_cyc    = cyc;
          done_capped = bus.match_capped_r;
          done_cnt    = bus.match_cnt_r;
        end
      end
    end
  end

  // Engine result and expected table command derived from the two head quantities.
  task automatic load_trade(input int bq, input int aq);
    search_result_t t;
    cmd_t           c;
    t.ask_price    = 32'(1000 + $urandom_range(0, 50));
    t.bid_price    = t.ask_price + 32'($urandom_range(0, 20));
    t.qty          = quantity_t'((bq < aq) ? bq : aq);
    t.remainder    = quantity_t'((bq > aq) ? bq - aq : aq - bq);
    t.bid_consumed = (bq <= aq);
    t.ask_consumed = (aq <= bq);
    if (bq == aq)     c = '{1'b1, 1'b1, 1'b0, 1'b0, quantity_t'(0)};
    else if (bq > aq) c = '{1'b0, 1'b1, 1'b1, 1'b0, quantity_t'(bq - aq)};
    else              c = '{1'b1, 1'b0, 1'b0, 1'b1, quantity_t'(aq - bq)};
    resp_q.push_back(t);
    if (n_loaded < MAX_TRADES) begin
      exp_trd.push_back(t);
      exp_cmd.push_back(c);
    end
    n_loaded++;
  endtask

  task automatic clear_script();
    resp_q.delete();
    exp_trd.delete();
    exp_cmd.delete();
    got_trd.delete();
    got_cmd.delete();
    qry_cycs.delete();
    n_loaded = 0;
  endtask

  task automatic pulse_req();
    @(posedge clk);
    #1 bus.match_req = 1'b1;
    @(posedge clk);
    #1 bus.match_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int target);
    for (int k = 0; k < 3000 && done_count < target; k++) @(posedge clk);
    checks++;
    if (done_count < target) begin
      fails++;
      $display("FAIL %s_timeout: got %0d done pulses expected %0d", name, done_count, target);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One full episode against the loaded script; timing from the per-trade cycle budget.
  task automatic run_ep(input string name, input int tbl_d, input int rdy_d);
    int c, d0, q0, n_exp, mx, per, lat_exp;
    logic capped_exp;
    tbl_dly = tbl_d;
    rdy_dly = rdy_d;
    got_trd.delete();
    got_cmd.delete();
    d0 = done_count;
    q0 = qry_seen;
    @(posedge clk);
    #1 c = cyc;
    bus.match_req = 1'b1;
    @(posedge clk);
    #1 bus.match_req = 1'b0;
    wait_done(name, d0 + 1);
    repeat (2) @(posedge clk);
    #1;
    n_exp      = (n_loaded < MAX_TRADES) ? n_loaded : MAX_TRADES;
    capped_exp = (n_loaded >= MAX_TRADES);
    mx         = (tbl_d > rdy_d) ? tbl_d : rdy_d;
    per        = 3 + mx + SETTLE_CYCLES;
    lat_exp    = capped_exp ? (MAX_TRADES - 1) * per + 4 + mx : 3 + n_exp * per;
    check_int({name, "_latency"}, done_cyc - c, lat_exp);
    check_int({name, "_capped"}, int'(done_capped), int'(capped_exp));
    check_int({name, "_cnt"}, int'(done_cnt), n_exp);
    check_int({name, "_qry_count"}, qry_seen - q0, capped_exp ? MAX_TRADES : n_exp + 1);
    check_int({name, "_trd_beats"}, got_trd.size(), n_exp);
    check_int({name, "_tbl_cmds"}, got_cmd.size(), n_exp);
    check_int({name, "_busy_after"}, int'(bus.match_busy), 0);
    for (int i = 0; i < n_exp && i < got_trd.size(); i++) begin
      checks++;
      if (got_trd[i] !== exp_trd[i]) begin
        fails++;
        $display("FAIL %s_trd[%0d]: got %h expected %h", name, i, got_trd[i], exp_trd[i]);
      end
    end
    for (int i = 0; i < n_exp && i < got_cmd.size(); i++) begin
      checks++;
      if (got_cmd[i] !== exp_cmd[i]) begin
        fails++;
        $display("FAIL %s_cmd[%0d]: got %h expected %h", name, i, got_cmd[i], exp_cmd[i]);
      end
    end
    clear_script();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outs() !== '0) begin
        fails++;
        $display("FAIL reset_outputs: got %h expected 0", outs());
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_no_trade();
    clear_script();
    run_ep("no_trade", 0, 0);
  endtask

  task automatic test_partial();
    clear_script();
    load_trade(10, 4);
    checks++;
    if (exp_trd[0].qty !== 16'd4 || exp_cmd[0].qty !== 16'd6) begin
      fails++;
      $display("FAIL partial_model: got qty %0d upd %0d expected 4 6", exp_trd[0].qty, exp_cmd[0].qty);
    end
    run_ep("partial", 0, 0);
  endtask

  task automatic test_equal();
    clear_script();
    load_trade(5, 5);
    run_ep("equal", 0, 0);
  endtask

  task automatic test_cap();
    clear_script();
    for (int i = 0; i < MAX_TRADES + 2; i++) load_trade($urandom_range(1, 40), $urandom_range(1, 40));
    run_ep("cap", 0, 0);
  endtask

  task automatic test_delayed();
    clear_script();
    load_trade($urandom_range(1, 40), $urandom_range(1, 40));
    load_trade(12, 12);
    run_ep("delayed", 3, 5);
  endtask

  task automatic test_random();
    for (int e = 0; e < 6; e++) begin
      int n;
      clear_script();
      n = $urandom_range(0, MAX_TRADES + 2);
      for (int i = 0; i < n; i++) load_trade($urandom_range(1, 50), $urandom_range(1, 50));
      run_ep($sformatf("random%0d", e), $urandom_range(0, 4), $urandom_range(0, 4));
    end
  endtask

  task automatic test_back_to_back();
    int d0, d1;
    clear_script();
    load_trade(7, 3);
    tbl_dly = 2;
    rdy_dly = 1;
    d0 = done_count;
    pulse_req();
    for (int k = 0; k < 50 && bus.trd_out_vld_r !== 1'b1; k++) @(negedge clk);
    check_int("b2b_reach_commit", int'(bus.trd_out_vld_r), 1);
    pulse_req();
    wait_done("b2b_first", d0 + 1);
    d1 = done_cyc;
    wait_done("b2b_second", d0 + 2);
    repeat (2) @(posedge clk);
    #1;
    check_int("b2b_qry_count", qry_cycs.size(), 3);
    if (qry_cycs.size() == 3) check_int("b2b_restart_cycle", qry_cycs[2], d1 + 1);
    check_int("b2b_second_cnt", int'(done_cnt), 0);
    check_int("b2b_trd_beats", got_trd.size(), 1);
    if (got_trd.size() == 1) begin
      checks++;
      if (got_trd[0] !== exp_trd[0]) begin
        fails++;
        $display("FAIL b2b_trd: got %h expected %h", got_trd[0], exp_trd[0]);
      end
    end
    clear_script();
  endtask

  task automatic test_reset_mid_commit();
    int d0, q0;
    clear_script();
    load_trade(9, 2);
    tbl_dly = 8;
    rdy_dly = 8;
    d0 = done_count;
    q0 = qry_seen;
    pulse_req();
    for (int k = 0; k < 50 && bus.trd_out_vld_r !== 1'b1; k++) @(negedge clk);
    check_int("rstmid_reach_commit", int'(bus.trd_out_vld_r), 1);
    pulse_req();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if (outs() !== '0) begin
      fails++;
      $display("FAIL rstmid_async_clear: got %h expected 0", outs());
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_int("rstmid_no_done", done_count - d0, 0);
    check_int("rstmid_no_requery", qry_seen - q0, 1);
    checks++;
    if (outs() !== '0) begin
      fails++;
      $display("FAIL rstmid_idle_after: got %h expected 0", outs());
    end
    clear_script();
  endtask

  initial begin
    bus.match_req = 1'b0;
    rst           = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_no_trade();
    test_partial();
    test_equal();
    test_cap();
    test_delayed();
    test_random();
    test_back_to_back();
    test_reset_mid_commit();
    test_no_trade();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
